oen_bus_reader: RTL

OEN_BUS_READER -- requirements
Module: oen_bus_reader

---
 rtl/oen_bus_reader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/oen_bus_reader.sv
// Scans a bank of output-enabled registers over one shared read bus, one enable at a time.
// Optional out_parity port and logic are enabled by defining OEN_BUS_READER_PARITY_EN.
module oen_bus_reader #(
    parameter int WIDTH  = 8,
    parameter int NREG   = 4,
    parameter int SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    start,
    input  logic [NREG-1:0]         mask,
    input  logic [WIDTH-1:0]        bus_in,
    output logic [NREG-1:0]         oen,
    output logic                    busy,
    output logic                    out_valid,
    output logic [$clog2(NREG)-1:0] out_idx,
    output logic [WIDTH-1:0]        out_data,
    output logic                    done
`ifdef OEN_BUS_READER_PARITY_EN
    ,
    output logic                    out_parity
`endif
);

    localparam int IDXW = $clog2(NREG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [NREG-1:0]   mask_reg, mask_next;
    logic [IDXW-1:0]   idx_reg, idx_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              capture;
    logic              out_valid_reg;
    logic [IDXW-1:0]   out_idx_reg;
    logic [WIDTH-1:0]  out_data_reg;

    // Lowest set bit wins; serviced bits are cleared, so this also yields ascending order.
    function automatic logic [IDXW-1:0] lowest(input logic [NREG-1:0] m);
        logic [IDXW-1:0] r;
        r = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (m[i]) r = IDXW'(i);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= IDLE;
            mask_reg  <= '0;
            idx_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            mask_reg  <= mask_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mask_next  = mask_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    mask_next = mask;
                    if (mask != '0) begin
                        state_next = DRIVE;
                        idx_next   = lowest(mask);
                        cnt_next   = 4'(SETTLE);
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DRIVE: begin
                if (cnt_reg == 4'd0) begin
                    capture    = 1'b1;
                    mask_next  = mask_reg & ~(NREG'(1) << idx_reg);
                    state_next = GAP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            GAP: begin
                if (mask_reg != '0) begin
                    state_next = DRIVE;
                    idx_next   = lowest(mask_reg);
                    cnt_next   = 4'(SETTLE);
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            out_valid_reg <= 1'b0;
            out_idx_reg   <= '0;
            out_data_reg  <= '0;
        end else begin
            out_valid_reg <= capture;
            if (capture) begin
                out_idx_reg  <= idx_reg;
                out_data_reg <= bus_in;
            end
        end
    end

    // Enables decode straight from the state register, so only one can ever be active.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_oen
            assign oen[gi] = (state_reg == DRIVE) && (idx_reg == IDXW'(gi));
        end
    endgenerate

    assign busy      = (state_reg == DRIVE) || (state_reg == GAP);
    assign done      = (state_reg == DONE);
    assign out_valid = out_valid_reg;
    assign out_idx   = out_idx_reg;
    assign out_data  = out_data_reg;

`ifdef OEN_BUS_READER_PARITY_EN
    logic parity_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            parity_reg <= 1'b0;
        end else if (capture) begin
            parity_reg <= ^bus_in;
        end
    end

    assign out_parity = parity_reg;
`endif

endmodule
